spi_ms: RTL and testbench

- Byte-wide SPI controller with an 8051-style SFR register interface, usable as master or slave (selected by the MSTR bit).
- In master mode it generates SCK from the system clock, drives MOSI and up to 8 active-low slave selects, and samples MISO.
- In slave mode it oversamples an external SCK/SS with the system clock.
- It raises an interrupt on byte completion. Two instances, one master and one slave, may be wired back to back.

---
 rtl/spi_ms.sv | 219 +++++++++++++++++++++
 tb/tb_spi_ms.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ms.sv
// Byte-wide SPI master/slave with an 8051-style SFR interface and a byte-complete interrupt.
// Master SCK half-period is 2^DIV clk; slave oversamples SCK/SS/MOSI through 2-flop synchronizers.
module spi_ms (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sfraddr_w,
  input  logic [2:0] sfraddr_r,
  input  logic       sfrwe,
  input  logic [7:0] spssn_i,
  input  logic [7:0] spidata_i,
  input  logic       mosii,
  input  logic       misoi,
  input  logic       scki,
  input  logic       ssn,
  output logic [7:0] spssn_o,
  output logic [7:0] sfrdatao,
  output logic       intspi,
  output logic       mosio,
  output logic       misoo,
  output logic       scko,
  output logic       SPC0
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t     r_state;
  logic       r_spie, r_spe, r_dord, r_mstr, r_cpol, r_cpha, r_spc0;
  logic [2:0] r_div;
  logic [7:0] r_txbuf, r_tx, r_rx, r_rxbuf, r_spssn;
  logic       r_spif, r_wcol, r_busy;
  logic [6:0] r_hcnt;
  logic [3:0] r_edge;
  logic       r_sckt, r_mosi, r_miso;
  logic [2:0] r_bitcnt;
  logic [2:0] r_scks, r_sss;
  logic [1:0] r_mosis;

  logic       w_master, w_slave, w_start, w_hdone, w_m_sample;
  logic       w_s_edge, w_s_lead, w_s_sample, w_ss_fall;
  logic [6:0] w_hmax;

  function automatic logic out_bit(input logic [7:0] d, input logic lsb);
    return lsb ? d[0] : d[7];
  endfunction

  function automatic logic [7:0] shift_out(input logic [7:0] d, input logic lsb);
    return lsb ? {1'b0, d[7:1]} : {d[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] shift_in(input logic [7:0] d, input logic b, input logic lsb);
    return lsb ? {b, d[7:1]} : {d[6:0], b};
  endfunction

  assign w_master   = r_spe & r_mstr;
  assign w_slave    = r_spe & ~r_mstr;
  assign w_start    = sfrwe && (sfraddr_w == 3'd3) && w_master && !r_busy && (r_state == S_IDLE);
  assign w_hmax     = (7'd1 << r_div) - 7'd1;
  assign w_hdone    = (r_hcnt == w_hmax);
  // Even edge indices are leading edges (away from CPOL).
  assign w_m_sample = r_cpha ? r_edge[0] : ~r_edge[0];
  assign w_s_edge   = r_scks[2] ^ r_scks[1];
  assign w_s_lead   = (r_scks[1] != r_cpol);
  assign w_s_sample = r_cpha ? ~w_s_lead : w_s_lead;
  assign w_ss_fall  = r_sss[2] & ~r_sss[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_spie   <= 1'b0;
      r_spe    <= 1'b0;
      r_dord   <= 1'b0;
      r_mstr   <= 1'b0;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_spc0   <= 1'b0;
      r_div    <= 3'd0;
      r_txbuf  <= 8'h00;
      r_tx     <= 8'h00;
      r_rx     <= 8'h00;
      r_rxbuf  <= 8'h00;
      r_spssn  <= 8'hFF;
      r_spif   <= 1'b0;
      r_wcol   <= 1'b0;
      r_busy   <= 1'b0;
      r_hcnt   <= 7'd0;
      r_edge   <= 4'd0;
      r_sckt   <= 1'b0;
      r_mosi   <= 1'b0;
      r_miso   <= 1'b0;
      r_bitcnt <= 3'd0;
      r_scks   <= 3'b000;
      r_sss    <= 3'b111;
      r_mosis  <= 2'b00;
    end else begin
      r_scks  <= {r_scks[1:0], scki};
      r_sss   <= {r_sss[1:0], ssn};
      r_mosis <= {r_mosis[0], mosii};
      r_spssn <= w_master ? spssn_i : 8'hFF;

      if (sfrwe) begin
        case (sfraddr_w)
          3'd0: {r_spie, r_spe, r_dord, r_mstr, r_cpol, r_cpha} <= spidata_i[7:2];
          3'd1: r_spc0 <= spidata_i[0];
          3'd2: r_div  <= spidata_i[2:0];
          3'd3: begin
            if (r_busy) r_wcol <= 1'b1;
            else begin
              r_txbuf <= spidata_i;
              r_tx    <= spidata_i;
            end
          end
          3'd4: begin
            if (spidata_i[7]) r_spif <= 1'b0;
            if (spidata_i[6]) r_wcol <= 1'b0;
          end
          default: ;
        endcase
      end

      if (w_slave) begin
        r_state <= S_IDLE;
        r_sckt  <= 1'b0;
        r_hcnt  <= 7'd0;
        r_edge  <= 4'd0;
        if (r_sss[1]) begin
          r_busy   <= 1'b0;
          r_miso   <= 1'b0;
          r_bitcnt <= 3'd0;
        end else if (w_ss_fall) begin
          r_busy   <= 1'b1;
          r_bitcnt <= 3'd0;
          if (!r_cpha) begin
            r_miso <= out_bit(r_txbuf, r_dord);
            r_tx   <= shift_out(r_txbuf, r_dord);
          end else begin
            r_tx   <= r_txbuf;
          end
        end else if (r_busy && w_s_edge) begin
          if (w_s_sample) begin
            r_rx     <= shift_in(r_rx, r_mosis[1], r_dord);
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_rxbuf <= shift_in(r_rx, r_mosis[1], r_dord);
              r_spif  <= 1'b1;
              r_tx    <= r_txbuf;
            end
          end else begin
            r_miso <= out_bit(r_tx, r_dord);
            r_tx   <= shift_out(r_tx, r_dord);
          end
        end
      end else begin
        r_miso   <= 1'b0;
        r_bitcnt <= 3'd0;
        case (r_state)
          S_IDLE: begin
            r_sckt <= 1'b0;
            r_hcnt <= 7'd0;
            r_edge <= 4'd0;
            r_busy <= w_start;
            if (w_start) begin
              r_state <= S_XFER;
              if (!r_cpha) begin
                r_mosi <= out_bit(spidata_i, r_dord);
                r_tx   <= shift_out(spidata_i, r_dord);
              end
            end
          end
          S_XFER: begin
            if (!w_master) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_sckt  <= 1'b0;
            end else if (w_hdone) begin
              r_hcnt <= 7'd0;
              r_sckt <= ~r_sckt;
              r_edge <= r_edge + 4'd1;
              if (w_m_sample) r_rx <= shift_in(r_rx, misoi, r_dord);
              else begin
                r_mosi <= out_bit(r_tx, r_dord);
                r_tx   <= shift_out(r_tx, r_dord);
              end
              if (r_edge == 4'd15) r_state <= S_DONE;
            end else begin
              r_hcnt <= r_hcnt + 7'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_rxbuf <= r_rx;
            r_spif  <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    sfrdatao = 8'h00;
    case (sfraddr_r)
      3'd0:    sfrdatao = {r_spie, r_spe, r_dord, r_mstr, r_cpol, r_cpha, 2'b00};
      3'd1:    sfrdatao = {7'd0, r_spc0};
      3'd2:    sfrdatao = {5'd0, r_div};
      3'd3:    sfrdatao = r_rxbuf;
      3'd4:    sfrdatao = {r_spif, r_wcol, 5'd0, r_busy};
      3'd5:    sfrdatao = r_spssn;
      default: sfrdatao = 8'h00;
    endcase
  end

  assign spssn_o = r_spssn;
  assign intspi  = r_spie & r_spif;
  assign mosio   = r_mosi;
  assign misoo   = r_miso;
  assign scko    = r_cpol ^ r_sckt;
  assign SPC0    = r_spc0;

endmodule

// File: tb/tb_spi_ms.sv
// Master/slave loopback bench for spi_ms: directed timing checks plus randomized byte exchanges.
module tb_spi_ms;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       m_we, s_we;
  logic [2:0] m_aw, m_ar, s_aw, s_ar;
  logic [7:0] m_wd, s_wd, m_spssn_i, s_spssn_i;
  logic [7:0] m_spssn_o, s_spssn_o, m_rd, s_rd;
  logic       m_int, m_mosio, m_misoo, m_scko, m_spc0;
  logic       s_int, s_mosio, s_misoo, s_scko, s_spc0;
  logic       frc_en, frc_val, m_misoi;

  assign m_misoi = frc_en ? frc_val : s_misoo;

  spi_ms u_m (
    .clk(clk), .rst_n(rst_n), .sfraddr_w(m_aw), .sfraddr_r(m_ar), .sfrwe(m_we),
    .spssn_i(m_spssn_i), .spidata_i(m_wd), .mosii(1'b0), .misoi(m_misoi),
    .scki(1'b0), .ssn(1'b1), .spssn_o(m_spssn_o), .sfrdatao(m_rd), .intspi(m_int),
    .mosio(m_mosio), .misoo(m_misoo), .scko(m_scko), .SPC0(m_spc0)
  );

  spi_ms u_s (
    .clk(clk), .rst_n(rst_n), .sfraddr_w(s_aw), .sfraddr_r(s_ar), .sfrwe(s_we),
    .spssn_i(s_spssn_i), .spidata_i(s_wd), .mosii(m_mosio), .misoi(1'b0),
    .scki(m_scko), .ssn(m_spssn_o[0]), .spssn_o(s_spssn_o), .sfrdatao(s_rd), .intspi(s_int),
    .mosio(s_mosio), .misoo(s_misoo), .scko(s_scko), .SPC0(s_spc0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic m_wr(input logic [2:0] a, input logic [7:0] d);
    m_aw = a; m_wd = d; m_we = 1'b1;
    tick();
    m_we = 1'b0;
  endtask

  task automatic s_wr(input logic [2:0] a, input logic [7:0] d);
    s_aw = a; s_wd = d; s_we = 1'b1;
    tick();
    s_we = 1'b0;
  endtask

  task automatic m_rdr(input logic [2:0] a, output logic [7:0] v);
    m_ar = a; #1; v = m_rd;
  endtask

  task automatic s_rdr(input logic [2:0] a, output logic [7:0] v);
    s_ar = a; #1; v = s_rd;
  endtask

  task automatic setup(input logic [1:0] mode, input logic dord, input logic [7:0] txs);
    frc_en = 1'b0;
    m_spssn_i = 8'hFF;
    m_wr(3'd0, {2'b01, dord, 1'b1, mode, 2'b00});
    s_wr(3'd0, {2'b01, dord, 1'b0, mode, 2'b00});
    m_wr(3'd2, 8'd3);
    repeat (6) tick();
    s_wr(3'd3, txs);
    m_wr(3'd4, 8'hC0);
    s_wr(3'd4, 8'hC0);
    m_spssn_i = 8'hFE;
    repeat (6) tick();
  endtask

  task automatic wait_mspif(input string tag);
    int n;
    logic [7:0] v;
    logic ok;
    n = 0;
    m_rdr(3'd4, v);
    while (!v[7] && n < 400) begin
      tick();
      m_rdr(3'd4, v);
      n++;
    end
    ok = (n < 400);
    chk(tag, {7'd0, ok}, 8'd1);
  endtask

  task automatic finish_xfer(input logic [7:0] txm, input logic [7:0] txs);
    logic [7:0] v;
    wait_mspif("m_spif_timeout");
    repeat (10) tick();
    m_spssn_i = 8'hFF;
    repeat (6) tick();
    m_rdr(3'd3, v); chk("m_rx", v, txs);
    s_rdr(3'd3, v); chk("s_rx", v, txm);
    s_rdr(3'd4, v); chk("s_spif", {7'd0, v[7]}, 8'd1);
  endtask

  task automatic xfer(input logic [1:0] mode, input logic dord, input logic [7:0] txm, input logic [7:0] txs);
    logic first;
    setup(mode, dord, txs);
    m_wr(3'd3, txm);
    repeat (11) tick();
    first = dord ? txm[0] : txm[7];
    chk("mosi_first", {7'd0, m_mosio}, {7'd0, first});
    finish_xfer(txm, txs);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v, a5, ta, tb;
    logic exp_bit;
    rst_n = 1'b0;
    m_we = 0; s_we = 0; m_aw = 0; s_aw = 0; m_ar = 0; s_ar = 0; m_wd = 0; s_wd = 0;
    m_spssn_i = 8'hFF; s_spssn_i = 8'hFF; frc_en = 1'b0; frc_val = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < 8; a++) begin
      m_rdr(a[2:0], v);
      chk($sformatf("rst_addr%0d", a), v, (a == 5) ? 8'hFF : 8'h00);
      tick();
    end
    chk("rst_scko", {7'd0, m_scko}, 8'd0);
    chk("rst_int", {7'd0, m_int}, 8'd0);
    chk("rst_spssn", m_spssn_o, 8'hFF);
    chk("rst_mosio", {7'd0, m_mosio}, 8'd0);

    frc_en = 1'b1; frc_val = 1'b1;
    m_spssn_i = 8'hFE;
    m_wr(3'd0, 8'h50);
    m_wr(3'd2, 8'd3);
    tick();
    chk("spssn_drive", m_spssn_o, 8'hFE);
    a5 = 8'hA5;
    m_wr(3'd3, a5);
    for (int t = 1; t <= 129; t++) begin
      tick();
      if (t % 16 == 4) chk($sformatf("sck_lo_t%0d", t), {7'd0, m_scko}, 8'd0);
      if (t % 16 == 12) chk($sformatf("sck_hi_t%0d", t), {7'd0, m_scko}, 8'd1);
      if (t % 16 == 8) begin
        exp_bit = a5[7 - t / 16];
        chk($sformatf("mosi_bit%0d", t / 16), {7'd0, m_mosio}, {7'd0, exp_bit});
      end
      if (t == 128) begin m_rdr(3'd4, v); chk("spif_t128", v, 8'h01); end
      if (t == 129) begin m_rdr(3'd4, v); chk("spif_t129", v, 8'h80); end
    end
    m_rdr(3'd3, v);
    chk("rx_ff", v, 8'hFF);
    m_spssn_i = 8'hFF;
    frc_en = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 20; i++) begin
      ta = 8'($urandom);
      tb = 8'($urandom);
      xfer(2'(i % 4), 1'($urandom_range(0, 1)), ta, tb);
    end

    xfer(2'd0, 1'b1, 8'h01, 8'h80);

    chk("int_off", {7'd0, m_int}, 8'd0);
    m_wr(3'd0, 8'hD0);
    chk("int_on", {7'd0, m_int}, 8'd1);
    m_wr(3'd4, 8'h80);
    chk("int_clr", {7'd0, m_int}, 8'd0);

    setup(2'd0, 1'b0, 8'h5A);
    m_aw = 3'd3; m_wd = 8'hC3; m_we = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      m_wd = 8'($urandom);
      tick();
    end
    m_we = 1'b0;
    m_rdr(3'd4, v);
    chk("wcol", {7'd0, v[6]}, 8'd1);
    finish_xfer(8'hC3, 8'h5A);

    frc_en = 1'b1; frc_val = 1'b1;
    m_wr(3'd0, 8'h58);
    m_wr(3'd4, 8'hC0);
    m_wr(3'd3, 8'h3C);
    repeat (20) tick();
    m_wr(3'd0, 8'h18);
    tick();
    chk("abort_scko", {7'd0, m_scko}, 8'd1);
    m_rdr(3'd4, v); chk("abort_spsr", v, 8'h00);
    repeat (150) tick();
    m_rdr(3'd4, v); chk("abort_nospif", v, 8'h00);
    m_rdr(3'd3, v); chk("abort_rx", v, 8'h5A);

    setup(2'd0, 1'b0, 8'h11);
    m_wr(3'd3, 8'h77);
    repeat (66) tick();
    m_spssn_i = 8'hFF;
    wait_mspif("part_m_spif");
    repeat (10) tick();
    s_rdr(3'd4, v); chk("part_s_spsr", v, 8'h00);
    s_rdr(3'd3, v); chk("part_s_rx", v, 8'hC3);

    frc_en = 1'b1;
    m_wr(3'd0, 8'h50);
    m_wr(3'd3, 8'h99);
    repeat (30) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_rdr(3'd0, v); chk("mrst_spcr", v, 8'h00);
    m_rdr(3'd4, v); chk("mrst_spsr", v, 8'h00);
    m_rdr(3'd3, v); chk("mrst_rx", v, 8'h00);
    chk("mrst_scko", {7'd0, m_scko}, 8'd0);
    chk("mrst_spssn", m_spssn_o, 8'hFF);
    chk("mrst_mosio", {7'd0, m_mosio}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
